// File: rtl/timer_ctrl.sv
// timer_ctrl: command sequencer and decrement prescaler for a chain of BCD countdown digit cells.
// Turns load/start/pause/clear commands into reconfig, reset_timer and decrement strobes and
// flags expiry once the chain reads back all zeros. Every output is registered.
module timer_ctrl #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    clear,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic                    reconfig,
    output logic [4*NUM_DIGITS-1:0] set_digits,
    output logic                    reset_timer,
    output logic                    decrement,
    output logic                    running,
    output logic                    expired,
    output logic                    expired_pulse
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StPause,
        StExpired
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;

    logic            reconfig_q, reconfig_d;
    logic [DW-1:0]   set_digits_q, set_digits_d;
    logic            reset_timer_q, reset_timer_d;
    logic            decrement_q, decrement_d;
    logic            running_q;
    logic            expired_q;
    logic            expired_pulse_q;

    logic            chain_zero;
    logic            zero_settled;
    logic            tick_due;
    logic            pause_cmd;

    // Clamp every nibble of a BCD preset to the legal digit range 0..9.
    function automatic logic [DW-1:0] sat_bcd(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    assign chain_zero = (digits_in == '0);
    // The chain value is only trusted once it has had a cycle to absorb the last strobe.
    assign zero_settled = chain_zero && !decrement_q;
    assign tick_due     = (pcnt_q == PCNT_MAX);
    // start outranks pause, so a simultaneous start masks the pause.
    assign pause_cmd    = pause && !start;

    // Next-state, prescaler and strobe decisions; command priority clear > load > start > pause.
    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        reconfig_d    = 1'b0;
        set_digits_d  = '0;
        reset_timer_d = 1'b0;
        decrement_d   = 1'b0;

        if (clear) begin
            state_d       = StIdle;
            pcnt_d        = '0;
            reset_timer_d = 1'b1;
        end else if (load && (state_q != StLoad)) begin
            state_d      = StLoad;
            pcnt_d       = '0;
            reconfig_d   = 1'b1;
            set_digits_d = sat_bcd(load_value);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !chain_zero) begin
                        state_d = StRun;
                        pcnt_d  = '0;
                    end
                end
                StLoad: begin
                    state_d = StIdle;
                    pcnt_d  = '0;
                end
                StRun: begin
                    if (zero_settled) begin
                        // Expiry wins over a tick falling due in the same cycle.
                        state_d = StExpired;
                    end else begin
                        // The cycle a pause is seen still counts as a run cycle.
                        pcnt_d      = tick_due ? '0 : pcnt_q + 1'b1;
                        decrement_d = tick_due;
                        if (pause_cmd) begin
                            state_d = StPause;
                        end
                    end
                end
                StPause: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StExpired: begin
                    state_d = StExpired;
                end
                default: begin
                    state_d = StIdle;
                    pcnt_d  = '0;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs; reset aborts any pending tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            pcnt_q          <= '0;
            reconfig_q      <= 1'b0;
            set_digits_q    <= '0;
            reset_timer_q   <= 1'b0;
            decrement_q     <= 1'b0;
            running_q       <= 1'b0;
            expired_q       <= 1'b0;
            expired_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pcnt_q          <= pcnt_d;
            reconfig_q      <= reconfig_d;
            set_digits_q    <= set_digits_d;
            reset_timer_q   <= reset_timer_d;
            decrement_q     <= decrement_d;
            running_q       <= (state_d == StRun);
            expired_q       <= (state_d == StExpired);
            expired_pulse_q <= (state_d == StExpired) && (state_q != StExpired);
        end
    end

    assign reconfig      = reconfig_q;
    assign set_digits    = set_digits_q;
    assign reset_timer   = reset_timer_q;
    assign decrement     = decrement_q;
    assign running       = running_q;
    assign expired       = expired_q;
    assign expired_pulse = expired_pulse_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed-plus-random bench for timer_ctrl with a behavioural BCD digit chain.
module tb_timer_ctrl;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned NUM_DIGITS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits_in;
    logic        reconfig;
    logic [15:0] set_digits;
    logic        reset_timer;
    logic        decrement;
    logic        running;
    logic        expired;
    logic        expired_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int viol    = 0;
    bit mon_en  = 1'b0;

    logic [15:0] chain_q = '0;
    assign digits_in = chain_q;

    timer_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .NUM_DIGITS(NUM_DIGITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_value   (load_value),
        .start        (start),
        .pause        (pause),
        .clear        (clear),
        .digits_in    (digits_in),
        .reconfig     (reconfig),
        .set_digits   (set_digits),
        .reset_timer  (reset_timer),
        .decrement    (decrement),
        .running      (running),
        .expired      (expired),
        .expired_pulse(expired_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model helpers: plain decimal arithmetic on BCD values.
    function automatic int bcd_to_int(input logic [15:0] v);
        int r = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            r += int'(v[4*i +: 4]) * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int n);
        logic [15:0] r = '0;
        int x = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_model(input logic [15:0] v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // Digit chain: load, zero or count down by one on the strobes it sees at each edge.
    always @(posedge clk) begin
        if (reconfig === 1'b1) begin
            chain_q <= set_digits;
        end else if (reset_timer === 1'b1) begin
            chain_q <= '0;
        end else if (decrement === 1'b1 && chain_q != 16'h0000) begin
            chain_q <= int_to_bcd(bcd_to_int(chain_q) - 1);
        end
    end

    // Strobe exclusivity and output-consistency watch, summarised by one comparison at the end.
    always @(posedge clk) begin
        if (mon_en) begin
            if ((reconfig && reset_timer) || (reconfig && decrement) ||
                (reset_timer && decrement) || (!reconfig && set_digits != 16'h0000) ||
                (expired_pulse && !expired) || (running && expired)) begin
                viol <= viol + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_reset_timer", {31'd0, reset_timer}, 32'd1);
        check("clear_expired_low", {31'd0, expired}, 32'd0);
        step();
        check("clear_strobe_one_cycle", {31'd0, reset_timer}, 32'd0);
    endtask

    task automatic countdown(input int n);
        logic [15:0] v;
        int s, ticks, first, last, exp_at, pulses, bad_gap;
        v = int_to_bcd(n);
        do_load(v);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        check("cd_running", {31'd0, running}, 32'd1);
        ticks = 0; first = -1; last = -1; exp_at = -1; pulses = 0; bad_gap = 0;
        for (int k = 0; k < int'(TICK_DIV) * n + 12; k++) begin
            step();
            if (decrement) begin
                if (ticks > 0 && cyc - last != int'(TICK_DIV)) bad_gap++;
                if (ticks == 0) first = cyc;
                last = cyc;
                ticks++;
            end
            if (expired_pulse) begin
                pulses++;
                if (exp_at < 0) exp_at = cyc;
            end
        end
        check("cd_tick_count", ticks, n);
        check("cd_first_tick", first, s + int'(TICK_DIV));
        check("cd_tick_spacing", bad_gap, 0);
        check("cd_expire_time", exp_at, s + int'(TICK_DIV) * n + 2);
        check("cd_expire_pulses", pulses, 1);
        check("cd_expired_level", {31'd0, expired}, 32'd1);
        check("cd_not_running", {31'd0, running}, 32'd0);
        // start and pause are ignored once expired
        start = 1'b1;
        pause = 1'b1;
        step();
        start = 1'b0;
        pause = 1'b0;
        check("exp_ignores_start", {30'd0, expired, running}, 32'd2);
        do_clear();
    endtask

    task automatic pause_run(input int p);
        int s, t, t2, k, bad;
        do_load(16'h0010);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        t = -1; k = 0;
        while (t < 0 && k < 12) begin
            step();
            k++;
            if (decrement) t = cyc;
        end
        check("pz_first_tick", t, s + int'(TICK_DIV));
        step();
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < p; i++) begin
            step();
            if (running || decrement) bad++;
        end
        pause = 1'b0;
        check("pz_frozen", bad, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("pz_resumed", {31'd0, running}, 32'd1);
        t2 = -1; k = 0;
        while (t2 < 0 && k < 12) begin
            step();
            k++;
            if (decrement) t2 = cyc;
        end
        check("pz_next_tick", t2, t + int'(TICK_DIV) + p);
        do_clear();
    endtask

    initial begin
        logic [15:0] v;
        int s, t, k, cnt;

        // Reset release
        reset = 1'b1;
        step();
        step();
        check("reset_outputs",
              {reconfig, set_digits, reset_timer, decrement, running, expired, expired_pulse}, 0);
        reset = 1'b0;
        step();
        check("post_reset_outputs",
              {reconfig, set_digits, reset_timer, decrement, running, expired, expired_pulse}, 0);
        mon_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_zero_ignored", {31'd0, running}, 32'd0);
        step();
        check("start_zero_idle", {31'd0, running}, 32'd0);

        // Load with nibble saturation
        do_load(16'h0A25);
        check("load_reconfig", {31'd0, reconfig}, 32'd1);
        check("load_sat", {16'd0, set_digits}, 32'h0925);
        step();
        check("load_reconfig_drop", {31'd0, reconfig}, 32'd0);
        check("load_set_zero", {16'd0, set_digits}, 32'd0);
        check("load_idle", {31'd0, running}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            do_load(v);
            check("rnd_load_sat", {15'd0, reconfig, set_digits}, {15'd0, 1'b1, sat_model(v)});
            step();
            check("rnd_load_after", {14'd0, reconfig, running, set_digits}, 32'd0);
        end

        // Countdown to expiry
        countdown(3);
        countdown(int'($urandom_range(1, 6)));
        countdown(12);

        // Pause extends the tick spacing
        pause_run(7);
        pause_run(int'($urandom_range(1, 10)));

        // All commands together while running: clear wins
        do_load(16'h0010);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1; pause = 1'b1; load = 1'b1; clear = 1'b1;
        load_value = 16'($urandom);
        step();
        start = 1'b0; pause = 1'b0; load = 1'b0; clear = 1'b0;
        check("multi_cmd_strobes", {28'd0, reset_timer, reconfig, decrement, running}, 32'h8);
        step();
        check("multi_cmd_after", {29'd0, reset_timer, reconfig, running}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (decrement || running || reconfig) cnt++;
        end
        check("multi_cmd_idle", cnt, 0);

        // Reset on the edge a tick would be issued
        do_load(16'h0005);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_run",
              {reconfig, set_digits, reset_timer, decrement, running, expired, expired_pulse}, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (decrement || running) cnt++;
        end
        check("reset_stays_idle", cnt, 0);
        // Chain keeps its value through reset, so a fresh start runs normally.
        start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        t = -1; k = 0;
        while (t < 0 && k < 12) begin
            step();
            k++;
            if (decrement) t = cyc;
        end
        check("restart_first_tick", t, s + int'(TICK_DIV));
        do_clear();

        check("strobe_invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing and tick-generation controller sitting directly upstream of the four-digit BCD countdown chain of `timer` digit cells. Converts operator commands (load, start, pause, clear) into the chain's `reconfig`/`setDigit`, `reset_timer` and `decrement` strobes. Paces decrements with a clock prescaler. Watches the digit values returned by the chain to flag expiry.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per decrement tick; legal range ≥ 2.
- `NUM_DIGITS`, 4: number of BCD digits driven; bus widths below are `4*NUM_DIGITS`.

- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `load` input 1: request to load `load_value` (level-sampled each cycle).
- `load_value` input 16: BCD preset; nibble 0 = least significant digit.
- `start` input 1: start or resume countdown.
- `pause` input 1: suspend countdown.
- `clear` input 1: zero the chain and return to IDLE.
- `digits_in` input 16: current digit values fed back from the chain.
- `reconfig` output 1: one-cycle load strobe to all digit cells.
- `set_digits` output 16: per-digit preset; valid while `reconfig`=1, else 0.
- `reset_timer` output 1: one-cycle zeroing strobe to all digit cells.
- `decrement` output 1: one-cycle tick to the least significant digit cell.
- `running` output 1: high in RUN.
- `expired` output 1: level, high in EXPIRED.
- `expired_pulse` output 1: one-cycle pulse on entry to EXPIRED.

## Operation
- States: IDLE, LOAD, RUN, PAUSE, EXPIRED. Prescaler `pcnt`, width `$clog2(TICK_DIV)`.
- Command priority per cycle: `reset` > `clear` > `load` > `start` > `pause`. Lower-priority commands in the same cycle are ignored.
- `clear` in any state:
  - Next cycle: `reset_timer`=1 for one cycle, state IDLE, `pcnt`=0.
  - `expired` drops.
- `load` in IDLE, RUN, PAUSE or EXPIRED:
  - Enter LOAD for exactly one cycle with `reconfig`=1.
  - `set_digits` = `load_value`, each nibble >9 saturated to 9.
  - Then go to IDLE, `pcnt`=0.
- IDLE:
  - `start` with `digits_in`≠0: go to RUN, `pcnt`=0.
  - `start` with `digits_in`=0: ignored.
  - `pause`: ignored.
- RUN:
  - `pcnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `decrement`=1 during the cycle in which `pcnt`=TICK_DIV-1.
  - If `digits_in`=0 and `decrement` was not asserted in the previous cycle: go to EXPIRED, with no `decrement` that cycle. The zero check beats the tick.
  - `pause`: go to PAUSE; `pcnt` holds its value.
- PAUSE:
  - `pcnt` frozen, no `decrement`.
  - `start`: back to RUN, counting resumes from the held `pcnt`.
- EXPIRED:
  - `expired`=1, no `decrement`.
  - `start` and `pause` are ignored.
  - Leave only via `clear` or `load`.
- `set_digits`=0 whenever `reconfig`=0.

## Timing
- Reset:
  - State IDLE, `pcnt`=0.
  - All outputs 0: `reconfig`, `set_digits`, `reset_timer`, `decrement`, `running`, `expired`, `expired_pulse`.
  - Reset mid-RUN aborts with no trailing `decrement`. The chain is not zeroed by this block on reset.
- All outputs are registered.
  - Command sampled at edge N → response visible after edge N+1.
- `reconfig` and `reset_timer` are never high together, and never high in the same cycle as `decrement`.
- First `decrement` after `start` at edge N occurs in the cycle after edge N+TICK_DIV.
  - Thereafter strictly every TICK_DIV cycles while in RUN.
  - PAUSE extends the spacing by exactly the number of paused cycles.
- Chain feedback latency: `digits_in` reflects a decrement one cycle after the strobe. TICK_DIV ≥ 2 guarantees the zero check sees settled data.
- Expiry: `expired_pulse` and `expired` rise one cycle after the first RUN cycle in which the settled `digits_in`=0.

## Test plan
- Use TICK_DIV=4 throughout. The bench models the digit chain behaviourally.
- Reset release: all outputs 0; `start` with `digits_in`=0 → remains IDLE, `running`=0.
- `load_value`=16'h0A25 → one `reconfig` pulse with `set_digits`=16'h0925; state IDLE; `set_digits`=0 the next cycle.
- Load 16'h0003, `start` → `decrement` pulses exactly 4 cycles apart, 3 pulses total. `expired_pulse` is one cycle, `expired` stays high, no 4th pulse.
- Load 16'h0010, `start`, `pause` 2 cycles after the first tick for 7 cycles, then `start` → next tick arrives 4+7 cycles after the first.
- `start`, `pause`, `load` and `clear` asserted in the same cycle during RUN → only the `reset_timer` pulse; state IDLE; no `reconfig`, no `decrement`.
- `reset` asserted one cycle before a due tick in RUN → no `decrement`; all outputs 0 next cycle; IDLE.
